inst_queue: RTL and testbench

Dual-issue instruction queue between the ICache fetch port and the ID stage. Accepts up to two sequential instructions per cycle from fetch and presents the two oldest entries to ID as inst1/inst2. It also provides the PCs, delay-slot flags and a single/dual issue hint. It keeps every branch together with its delay slot, and it absorbs ICache stalls and ID back-pressure.

---
 rtl/inst_queue_pkg.sv | 35 +++
 rtl/inst_queue_if.sv | 49 ++++
 rtl/inst_queue_branch_detect.sv | 35 +++
 rtl/inst_queue.sv | 117 +++++++++++
 tb/tb_inst_queue.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_queue_pkg.sv
// inst_queue shared types and constants.
// Opcode/funct values are the MIPS32 branch and jump encodings.
package inst_queue_pkg;

    localparam int unsigned IQ_DEPTH = 16;

    typedef enum logic {
        SingleIssue = 1'b0,
        DualIssue   = 1'b1
    } issue_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        br;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push port and ID-side issue port of the instruction queue.
// The queue itself uses the slave modport; fetch/ID drive through master.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic        push_valid1_i;
    logic        push_valid2_i;
    logic [31:0] push_inst1_i;
    logic [31:0] push_inst2_i;
    logic [31:0] push_pc_i;
    logic        full_o;

    logic        stall_i;
    logic        flush_i;
    logic [1:0]  issued_i;

    logic [31:0] inst1_o;
    logic [31:0] inst2_o;
    logic [31:0] pc1_o;
    logic [31:0] pc2_o;
    logic        inst1_valid_o;
    logic        inst2_valid_o;
    logic        is_in_delayslot1_o;
    logic        is_in_delayslot2_o;
    issue_t      issue_o;

    modport slave (
        input  push_valid1_i, push_valid2_i,
        input  push_inst1_i, push_inst2_i, push_pc_i,
        output full_o,
        input  stall_i, flush_i, issued_i,
        output inst1_o, inst2_o, pc1_o, pc2_o,
        output inst1_valid_o, inst2_valid_o,
        output is_in_delayslot1_o, is_in_delayslot2_o,
        output issue_o
    );

    modport master (
        output push_valid1_i, push_valid2_i,
        output push_inst1_i, push_inst2_i, push_pc_i,
        input  full_o,
        output stall_i, flush_i, issued_i,
        input  inst1_o, inst2_o, pc1_o, pc2_o,
        input  inst1_valid_o, inst2_valid_o,
        input  is_in_delayslot1_o, is_in_delayslot2_o,
        input  issue_o
    );

endinterface

// File: rtl/inst_queue_branch_detect.sv
// Classifies an instruction word as a branch/jump that owns a delay slot.
// Shared with ID's jump detection so both agree on what a branch is.
module branch_detect
    import inst_queue_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_branch
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_bits;

    assign op    = inst[31:26];
    assign rt    = inst[20:16];
    assign funct = inst[5:0];
    assign unused_bits = ^{inst[25:21], inst[15:6]};

    always_comb begin
        is_branch = 1'b0;
        unique case (op)
            OP_SPECIAL:
                is_branch = (funct == FN_JR) || (funct == FN_JALR);
            OP_REGIMM:
                is_branch = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                            (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                is_branch = 1'b1;
            default:
                is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between ICache fetch and ID.
// Keeps each branch paired with its delay slot; outputs are registered-state only.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
)
(
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  io
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_TWO  = cnt_t'(2);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH - 1);

    iq_entry_t mem [DEPTH];
    ptr_t      head;
    ptr_t      tail;
    cnt_t      count;
    logic      last_br_q;

    ptr_t      head1;
    ptr_t      tail1;
    iq_entry_t e1;
    iq_entry_t e2;
    logic      br1;
    logic      br2;
    logic      v1;
    logic      v2;
    logic      full;
    logic [1:0] push_n;
    logic [1:0] pop_n;
    logic [1:0] offer_n;
    cnt_t      count_next;

    branch_detect u_bd1 (.inst(io.push_inst1_i), .is_branch(br1));
    branch_detect u_bd2 (.inst(io.push_inst2_i), .is_branch(br2));

    assign head1 = head + ptr_t'(1);
    assign tail1 = tail + ptr_t'(1);
    assign e1    = mem[head];
    assign e2    = mem[head1];

    // A branch at the head waits for its slot; a branch never sits in slot 2.
    assign v1   = (count >= CNT_ONE) && !(e1.br && (count < CNT_TWO));
    assign v2   = v1 && (count >= CNT_TWO) && !e2.br;
    assign full = (count >= CNT_FULL);

    always_comb begin
        push_n  = 2'd0;
        pop_n   = 2'd0;
        offer_n = {1'b0, v1} + {1'b0, v2};
        if (!io.flush_i && !full && io.push_valid1_i)
            push_n = io.push_valid2_i ? 2'd2 : 2'd1;
        if (!io.stall_i && !io.flush_i)
            pop_n = (io.issued_i > offer_n) ? offer_n : io.issued_i;
    end

    assign count_next = count + cnt_t'(push_n) - cnt_t'(pop_n);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            last_br_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (io.flush_i) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            last_br_q <= 1'b0;
        end else begin
            if (push_n != 2'd0)
                mem[tail] <= '{inst: io.push_inst1_i,
                               pc:   io.push_pc_i,
                               br:   br1};
            if (push_n == 2'd2)
                mem[tail1] <= '{inst: io.push_inst2_i,
                                pc:   io.push_pc_i + 32'd4,
                                br:   br2};
            if (pop_n == 2'd2)
                last_br_q <= e2.br;
            else if (pop_n == 2'd1)
                last_br_q <= e1.br;
            head  <= head + ptr_t'(pop_n);
            tail  <= tail + ptr_t'(push_n);
            count <= count_next;
        end
    end

    // Fetch is expected to honour full_o; a push here is silently dropped.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst)
        !(full && io.push_valid1_i)
    );

    assign io.full_o             = full;
    assign io.inst1_o            = e1.inst;
    assign io.inst2_o            = e2.inst;
    assign io.pc1_o              = e1.pc;
    assign io.pc2_o              = e2.pc;
    assign io.inst1_valid_o      = v1;
    assign io.inst2_valid_o      = v2;
    assign io.is_in_delayslot1_o = last_br_q;
    assign io.is_in_delayslot2_o = e1.br;
    assign io.issue_o            = v2 ? DualIssue : SingleIssue;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue.
// A reference queue holds every pushed entry; issued entries are popped and compared.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam logic [31:0] ADDU   = 32'h0043_0821;
    localparam logic [31:0] SUBU   = 32'h0043_0823;
    localparam logic [31:0] BEQ    = 32'h1022_0004;
    localparam logic [31:0] JAL    = 32'h0C00_0040;
    localparam logic [31:0] JR     = 32'h03E0_0008;
    localparam logic [31:0] BLTZAL = 32'h0430_0003;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        br;
    } sb_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    sb_t  sbq[$];
    logic last_br;

    inst_queue_if iq ();

    inst_queue #(.DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_br(input logic [31:0] w);
        case (w[31:26])
            6'd0:    return w[5:1] == 5'b00100;
            6'd1:    return w[19:17] == 3'b000;
            6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_v1();
        int n = sbq.size();
        if (n == 0) return 1'b0;
        return !(sbq[0].br && n < 2);
    endfunction

    function automatic logic exp_v2();
        int n = sbq.size();
        return exp_v1() && n >= 2 && !sbq[1].br;
    endfunction

    task automatic check_offer();
        logic ev1 = exp_v1();
        logic ev2 = exp_v2();
        chk("inst1_valid", 32'(iq.inst1_valid_o), 32'(ev1));
        chk("inst2_valid", 32'(iq.inst2_valid_o), 32'(ev2));
        chk("issue", 32'(iq.issue_o),
            32'(ev2 ? DualIssue : SingleIssue));
        chk("full", 32'(iq.full_o), 32'(sbq.size() >= 15));
        chk("ds1", 32'(iq.is_in_delayslot1_o), 32'(last_br));
        if (sbq.size() >= 1)
            chk("ds2", 32'(iq.is_in_delayslot2_o), 32'(sbq[0].br));
        if (ev1) begin
            chk("inst1", iq.inst1_o, sbq[0].inst);
            chk("pc1", iq.pc1_o, sbq[0].pc);
        end
        if (ev2) begin
            chk("inst2", iq.inst2_o, sbq[1].inst);
            chk("pc2", iq.pc2_o, sbq[1].pc);
        end
    endtask

    // One clock: check current offer, drive, update the reference, advance.
    task automatic cycle(input logic pv1, input logic pv2,
                         input logic [31:0] i1, input logic [31:0] i2,
                         input logic [31:0] pc, input logic fl,
                         input logic [1:0] iss);
        int offer;
        int pop;
        check_offer();
        iq.push_valid1_i = pv1;
        iq.push_valid2_i = pv2;
        iq.push_inst1_i  = i1;
        iq.push_inst2_i  = i2;
        iq.push_pc_i     = pc;
        iq.flush_i       = fl;
        iq.stall_i       = 1'b0;
        iq.issued_i      = iss;
        offer = int'(exp_v1()) + int'(exp_v2());
        pop   = fl ? 0 : ((int'(iss) > offer) ? offer : int'(iss));
        if (fl) begin
            sbq.delete();
            last_br = 1'b0;
        end else begin
            for (int k = 0; k < pop; k++) begin
                last_br = sbq[0].br;
                void'(sbq.pop_front());
            end
            if (pv1) sbq.push_back('{i1, pc, is_br(i1)});
            if (pv1 && pv2) sbq.push_back('{i2, pc + 32'd4, is_br(i2)});
        end
        @(posedge clk);
        #1;
        iq.push_valid1_i = 1'b0;
        iq.push_valid2_i = 1'b0;
        iq.flush_i       = 1'b0;
        iq.issued_i      = 2'd0;
    endtask

    task automatic idle(input logic [1:0] iss);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, iss);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_v1"}, 32'(iq.inst1_valid_o), 32'h0);
        chk({tag, "_v2"}, 32'(iq.inst2_valid_o), 32'h0);
        chk({tag, "_full"}, 32'(iq.full_o), 32'h0);
        chk({tag, "_issue"}, 32'(iq.issue_o), 32'(SingleIssue));
        chk({tag, "_inst1"}, iq.inst1_o, 32'h0);
        chk({tag, "_pc2"}, iq.pc2_o, 32'h0);
        chk({tag, "_ds1"}, 32'(iq.is_in_delayslot1_o), 32'h0);
        chk({tag, "_ds2"}, 32'(iq.is_in_delayslot2_o), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_br  = 1'b0;
        rst      = 1'b0;
        iq.push_valid1_i = 1'b0;
        iq.push_valid2_i = 1'b0;
        iq.push_inst1_i  = '0;
        iq.push_inst2_i  = '0;
        iq.push_pc_i     = '0;
        iq.stall_i       = 1'b0;
        iq.flush_i       = 1'b0;
        iq.issued_i      = 2'd0;

        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // plain dual pair
        cycle(1'b1, 1'b1, ADDU, SUBU, 32'h100, 1'b0, 2'd0);
        chk("pair_pc2", iq.pc2_o, 32'h104);
        chk("pair_dual", 32'(iq.issue_o), 32'(DualIssue));
        idle(2'd2);

        // branch waits for its delay slot
        cycle(1'b1, 1'b0, BEQ, 32'h0, 32'h200, 1'b0, 2'd2);
        chk("beq_wait", 32'(iq.inst1_valid_o), 32'h0);
        cycle(1'b1, 1'b0, ADDU, 32'h0, 32'h204, 1'b0, 2'd2);
        chk("beq_pair_ds2", 32'(iq.is_in_delayslot2_o), 32'h1);
        idle(2'd2);

        // branch at head+1 blocks slot 2, then pairs with its slot
        cycle(1'b1, 1'b1, ADDU, JAL, 32'h300, 1'b0, 2'd0);
        chk("jal_v2", 32'(iq.inst2_valid_o), 32'h0);
        idle(2'd1);
        chk("jal_alone", 32'(iq.inst1_valid_o), 32'h0);
        cycle(1'b1, 1'b0, SUBU, 32'h0, 32'h308, 1'b0, 2'd0);
        chk("jal_pair", 32'(iq.inst2_valid_o), 32'h1);
        idle(2'd2);

        // dual offered, single consumed: slot promotes with ds1 set
        cycle(1'b1, 1'b1, BLTZAL, ADDU, 32'h400, 1'b0, 2'd0);
        idle(2'd1);
        chk("promote_pc1", iq.pc1_o, 32'h404);
        chk("promote_ds1", 32'(iq.is_in_delayslot1_o), 32'h1);
        cycle(1'b1, 1'b1, JR, SUBU, 32'h500, 1'b0, 2'd1);
        idle(2'd3);
        idle(2'd2);

        // fill to 14 across the pointer wrap
        for (int k = 0; k < 7; k++)
            cycle(1'b1, 1'b1, ADDU | (32'(k) << 11), SUBU | (32'(k) << 11),
                  32'h1000 + 32'(k) * 8, 1'b0, 2'd0);
        chk("fill14_full", 32'(iq.full_o), 32'h0);
        cycle(1'b1, 1'b1, ADDU | 32'h7800, SUBU, 32'h2000, 1'b0, 2'd2);
        chk("fill14_keep", 32'(iq.pc1_o), 32'h1008);
        cycle(1'b1, 1'b0, JR, 32'h0, 32'h2008, 1'b0, 2'd0);
        chk("fill15_full", 32'(iq.full_o), 32'h1);
        for (int k = 0; k < 9; k++)
            idle(2'd2);

        // flush discards a simultaneous push
        cycle(1'b1, 1'b1, ADDU, SUBU, 32'h600, 1'b0, 2'd0);
        cycle(1'b1, 1'b1, SUBU, ADDU, 32'h608, 1'b1, 2'd2);
        chk("flush_v1", 32'(iq.inst1_valid_o), 32'h0);
        chk("flush_v2", 32'(iq.inst2_valid_o), 32'h0);

        // asynchronous reset mid-stream
        cycle(1'b1, 1'b1, BEQ, ADDU, 32'h700, 1'b0, 2'd0);
        check_offer();
        #2;
        rst = 1'b0;
        #1;
        sbq.delete();
        last_br = 1'b0;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b1, SUBU, ADDU, 32'h800, 1'b0, 2'd0);
        idle(2'd2);
        check_offer();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
